// File: rtl/rsa_montgomery.sv
// ---------------------------------------------------------------------------
// rsa_montgomery
//
// Bit-serial radix-2 Montgomery multiplier for the RSA core. It computes
// o_m = a * b * 2^-W mod N, one bit of a per clock, LSB first. The
// exponentiation controller uses it for each square-and-multiply step. One
// operand is usually the y * 2^W mod N value from the modulo-product pre-stage.
//
// Ports
//   i_clk     clock; all state updates on the rising edge
//   i_rst_n   synchronous, active-low reset (abandons a run in progress)
//   i_start   start request; only honoured in S_IDLE
//   i_n       modulus N (odd, N > a, N > b); captured on the accepting edge
//   i_a       multiplier a; captured, then scanned LSB first
//   i_b       multiplicand b; captured on the accepting edge
//   o_m       result; valid with o_finish, held until the next S_FINAL/reset
//   o_finish  single-cycle pulse marking o_m valid
//   o_busy    high from the start-accept edge until the edge raising o_finish
//
// Timing: start accepted at edge E0, iterations at E1..EW, and o_finish is
// raised by edge E(W+1). A start during the o_finish cycle is accepted, so
// back-to-back runs repeat every W+2 cycles.
// ---------------------------------------------------------------------------
module rsa_montgomery #(
    parameter int W = 256
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_n,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_m,
    output logic         o_finish,
    output logic         o_busy
);

    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FINAL
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [W-1:0]       n_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;

    // The accumulator stays below 2N between iterations. m + b + N is below 4N,
    // so two extra bits are enough to hold the sum without overflow.
    logic [W+1:0]       m;
    logic [W+1:0]       t_add;
    logic [W+1:0]       t_red;

    // Final reduction. The loop leaves m in [0, 2N), so a single conditional
    // subtraction brings it into [0, N).
    function automatic logic [W-1:0] final_reduce(input logic [W+1:0] acc,
                                                  input logic [W-1:0] n);
        return W'((acc >= {2'b00, n}) ? acc - {2'b00, n} : acc);
    endfunction

    // One radix-2 step. Add b if the current bit of a is set. Then add N when
    // the sum is odd, so that the halving below is exact.
    always_comb begin
        t_add = m + (a_r[counter] ? {2'b00, b_r} : '0);
        t_red = t_add + (t_add[0] ? {2'b00, n_r} : '0);
    end

    // Operand capture on the accepting edge. These registers are pure data
    // and need no reset, because every run loads them before they are used.
    always_ff @(posedge i_clk) begin
        if (state == S_IDLE && i_start) begin
            n_r <= i_n;
            a_r <= i_a;
            b_r <= i_b;
        end
    end

    // Control FSM, accumulator and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            counter  <= '0;
            m        <= '0;
            o_m      <= '0;
            o_finish <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_finish <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        m       <= '0;
                        counter <= '0;
                        o_busy  <= 1'b1;
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    m <= t_red >> 1;
                    // Hold the counter on the last iteration so that it never
                    // wraps within a run. It is cleared again on the next accept.
                    if (counter == CNT_W'(W - 1)) begin
                        state <= S_FINAL;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                S_FINAL: begin
                    o_m      <= final_reduce(m, n_r);
                    o_finish <= 1'b1;
                    o_busy   <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_montgomery.sv
// ---------------------------------------------------------------------------
// tb_rsa_montgomery
//
// Self-checking bench for rsa_montgomery (W = 256).
//
// Every accepted start pushes an entry onto a scoreboard. Each entry holds the
// operands, a hand-derived result when one is known, and the start edge.
//
// On every o_finish pulse a monitor pops the oldest entry and checks these
// properties of the result:
//   - latency from the start edge
//   - length of the o_busy window
//   - pulse width of o_finish
//   - the exact value, when it is known
//   - o_m * 2^W == a * b (mod N)
//   - o_m < N
// The last two properties together fix the result uniquely for odd N.
// ---------------------------------------------------------------------------
module tb_rsa_montgomery;

    localparam int W = 256;

    typedef struct {
        logic [W-1:0] n;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        bit           known;
        int           start_edge;
    } sb_entry_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] n_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] m_out;
    logic         finish;
    logic         busy;

    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    sb_entry_t    sb[$];
    bit           mon_en = 1'b0;
    bit           prev_fin = 1'b0;
    int           busy_cnt = 0;

    sb_entry_t    mon_e;
    logic [2*W-1:0] wide_n;
    logic [2*W-1:0] lhs;
    logic [2*W-1:0] rhs;

    rsa_montgomery #(.W(W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_n      (n_in),
        .i_a      (a_in),
        .i_b      (b_in),
        .o_m      (m_out),
        .o_finish (finish),
        .o_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [W-1:0] got,
                            input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (finish === 1'b1) begin
                check_eq("finish_width", W'(prev_fin), W'(0));
                check_eq("busy_len", W'(busy_cnt), W'(W + 1));
                if (sb.size() == 0) begin
                    check_eq("unexpected_finish", W'(1), W'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("latency", W'(cyc - mon_e.start_edge), W'(W + 1));
                    if (mon_e.known) check_eq("result", m_out, mon_e.exp);
                    wide_n = {{W{1'b0}}, mon_e.n};
                    lhs = {m_out, {W{1'b0}}} % wide_n;
                    rhs = ({{W{1'b0}}, mon_e.a} * {{W{1'b0}}, mon_e.b}) % wide_n;
                    check_eq("congruence", W'(lhs), W'(rhs));
                    check_eq("range", W'(m_out < mon_e.n), W'(1));
                end
                busy_cnt = 0;
            end else if (busy === 1'b1) begin
                busy_cnt++;
            end else begin
                busy_cnt = 0;
            end
            prev_fin = (finish === 1'b1);
        end
    end

    // Called at a falling edge: drives a start for the next rising edge.
    task automatic drive_start(input logic [W-1:0] n, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] exp,
                               input bit known);
        sb_entry_t e;
        n_in  = n;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        e.n = n; e.a = a; e.b = b; e.exp = exp; e.known = known;
        e.start_edge = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_finish(output int fe);
        bit found = 1'b0;
        fe = 0;
        for (int k = 0; k < 2 * W + 50; k++) begin
            @(negedge clk);
            if (finish === 1'b1) begin
                found = 1'b1;
                fe = cyc;
                break;
            end
        end
        if (!found) check_eq("finish_timeout", W'(0), W'(1));
    endtask

    task automatic run_one(input logic [W-1:0] n, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp,
                           input bit known);
        int fe;
        @(negedge clk);
        drive_start(n, a, b, exp, known);
        @(negedge clk);
        start = 1'b0;
        wait_finish(fe);
        @(negedge clk);
        check_eq("finish_clear", W'(finish), W'(0));
        if (known) check_eq("o_m_hold", m_out, exp);
    endtask

    task automatic count_finishes(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (finish === 1'b1) cnt++;
        end
    endtask

    initial begin
        int           e1;
        int           e2;
        int           s;
        int           extra;
        bit           found;
        logic [W-1:0] nmax;
        logic [W-1:0] nm1;
        logic [W-1:0] rn;

        rst_n = 1'b0;
        start = 1'b0;
        n_in  = '0;
        a_in  = '0;
        b_in  = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("idle_o_m", m_out, W'(0));
            check_eq("idle_finish", W'(finish), W'(0));
            check_eq("idle_busy", W'(busy), W'(0));
        end

        // Basic: R = 2 mod 7, R^-1 = 4, so 15 * 4 mod 7 = 4
        run_one(W'(7), W'(3), W'(5), W'(4), 1'b1);

        // Back-to-back: R = 1 mod 5 and mod 3; second start during o_finish
        @(negedge clk);
        drive_start(W'(5), W'(3), W'(4), W'(2), 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_finish(e1);
        drive_start(W'(3), W'(2), W'(2), W'(1), 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_finish(e2);
        check_eq("b2b_gap", W'(e2 - e1), W'(W + 2));
        @(negedge clk);
        check_eq("b2b_hold", m_out, W'(1));

        // Max width: N = 2^W - 1, so R = 1 mod N and (N-1)^2 = 1 mod N
        nmax = '1;
        nm1  = nmax - 1'b1;
        run_one(nmax, nm1, nm1, W'(1), 1'b1);
        run_one(nmax, W'(0), nm1, W'(0), 1'b1);

        // Start while busy, with the inputs changing every cycle
        @(negedge clk);
        drive_start(W'(7), W'(3), W'(5), W'(4), 1'b1);
        s = cyc + 1;
        found = 1'b0;
        for (int k = 0; k < 2 * W + 50; k++) begin
            @(negedge clk);
            if (finish === 1'b1) begin
                found = 1'b1;
                break;
            end
            n_in  = rand_w();
            b_in  = rand_w();
            a_in  = (cyc == s + 99) ? W'(6) : rand_w();
            start = (cyc == s + 99);
        end
        check_eq("busy_run_done", W'(found), W'(1));
        start = 1'b0;
        count_finishes(300, extra);
        check_eq("no_second_run", W'(extra), W'(0));

        // Reset mid-run abandons the run
        @(negedge clk);
        drive_start(W'(7), W'(3), W'(5), W'(4), 1'b1);
        s = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 119) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb.pop_back());
        check_eq("rst_o_m", m_out, W'(0));
        check_eq("rst_busy", W'(busy), W'(0));
        check_eq("rst_finish", W'(finish), W'(0));
        count_finishes(300, extra);
        check_eq("rst_no_finish", W'(extra), W'(0));
        run_one(W'(7), W'(3), W'(5), W'(4), 1'b1);

        // Random large odd moduli with a, b < N
        for (int r = 0; r < 3; r++) begin
            rn = rand_w();
            rn[0] = 1'b1;
            rn[W-1] = 1'b1;
            run_one(rn, rand_w() % rn, rand_w() % rn, W'(0), 1'b0);
        end

        repeat (3) @(negedge clk);
        check_eq("sb_empty", W'(sb.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
